// File: rtl/glyph_serializer_pkg.sv
// Font geometry shared by the glyph serializer files.
// The optional GLYPH_INVERSE_EN macro is handled in glyph_serializer.sv.
package glyph_serializer_pkg;
    localparam int GLYPH_W        = 8;     // pixels per glyph row == ROM data width
    localparam int GLYPH_H        = 16;    // rows per glyph
    localparam int FONT_ADDR_W    = 12;    // {char, row}
    localparam int FONT_ROM_DEPTH = 4096;
    localparam int CHAR_BITS      = 8;
    localparam int ROW_BITS       = $clog2(GLYPH_H);

    typedef logic [GLYPH_W-1:0] glyph_byte_t;
endpackage

// File: rtl/glyph_serializer_if.sv
// Character request channel between text/timing logic and the serializer.
interface glyph_serializer_if #(
    parameter int CHAR_BITS = 8,
    parameter int ROW_BITS  = 4
);
    logic                 char_valid;
    logic                 char_ready;
    logic [CHAR_BITS-1:0] char_code;
    logic [ROW_BITS-1:0]  char_row;
    logic                 char_inv;

    modport master (output char_valid, char_code, char_row, char_inv, input char_ready);
    modport slave  (input char_valid, char_code, char_row, char_inv, output char_ready);
endinterface

// File: rtl/glyph_serializer_shifter.sv
// glyph_shifter: one glyph row shifted out MSB-first, one pixel per clk.
// 'last' marks the final bit, the only cycle (besides idle) where a load is legal.
module glyph_shifter #(
    parameter int GLYPH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [GLYPH_W-1:0] din,
    output logic               pixel,
    output logic               active,
    output logic               last
);
    localparam int CNT_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(GLYPH_W - 1);

    logic [GLYPH_W-1:0] shreg;
    logic [CNT_W-1:0]   bit_cnt;

    assign pixel = shreg[GLYPH_W-1];
    assign last  = active && (bit_cnt == LAST_BIT);

    // Load, shift, or retire; shreg is cleared on retire so an idle pixel reads 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            active  <= 1'b0;
        end else if (load) begin
            shreg   <= din;
            bit_cnt <= '0;
            active  <= 1'b1;
        end else if (active) begin
            if (bit_cnt == LAST_BIT) begin
                shreg   <= '0;
                bit_cnt <= '0;
                active  <= 1'b0;
            end else begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/glyph_serializer.sv
// glyph_serializer: font ROM reader + pixel serializer.
// Fetch pipe: accept -> s1 (address registered) -> s2 (ROM data valid) -> shifter or hold.
// Optional macro GLYPH_INVERSE_EN: XOR the byte with char_inv as it enters shifter/hold.
module glyph_serializer
    import glyph_serializer_pkg::*;
#(
    parameter int CHAR_BITS = glyph_serializer_pkg::CHAR_BITS,
    parameter int ROW_BITS  = glyph_serializer_pkg::ROW_BITS,
    parameter int GLYPH_W   = glyph_serializer_pkg::GLYPH_W
) (
    input  logic                          clk,
    input  logic                          reset,
    glyph_serializer_if.slave             chr,
    output logic [CHAR_BITS+ROW_BITS-1:0] rom_addr,
    input  logic [GLYPH_W-1:0]            rom_dout,
    output logic                          pixel,
    output logic                          pixel_valid,
    output logic                          underrun,
    input  logic                          clear_underrun
);
    logic               s1_v, s2_v, hold_v;
    logic [GLYPH_W-1:0] hold_q, byte_in, sh_din;
    logic               accept, want, sh_load, sh_active, sh_last, underrun_set;

    // Only one fetch may be anywhere in the pipe or hold at a time.
    assign chr.char_ready = !s1_v && !s2_v && !hold_v;
    assign accept         = chr.char_valid && chr.char_ready;

`ifdef GLYPH_INVERSE_EN
    logic inv1, inv2;

    // Inverse attribute travels alongside the fetch so it meets its own ROM byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv1 <= 1'b0;
            inv2 <= 1'b0;
        end else begin
            if (accept) inv1 <= chr.char_inv;
            if (s1_v)   inv2 <= inv1;
        end
    end
    assign byte_in = rom_dout ^ {GLYPH_W{inv2}};
`else
    logic unused_inv;
    assign unused_inv = chr.char_inv;
    assign byte_in    = rom_dout;
`endif

    // Fetch pipe: address on accept, ROM data usable one stage later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr <= '0;
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
        end else begin
            if (accept) rom_addr <= {chr.char_code, chr.char_row};
            s1_v <= accept;
            s2_v <= s1_v;
        end
    end

    // Shifter takes new data when idle or on its last bit; fresh ROM data beats hold.
    assign want    = !sh_active || sh_last;
    assign sh_load = want && (s2_v || hold_v);
    assign sh_din  = s2_v ? byte_in : hold_q;

    // Hold register parks a byte that arrives while the shifter is mid-row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_v <= 1'b0;
            hold_q <= '0;
        end else if (s2_v && !want) begin
            hold_v <= 1'b1;
            hold_q <= byte_in;
        end else if (hold_v && want && !s2_v) begin
            hold_v <= 1'b0;
        end
    end

    // Starved only if a fetch is still pending when the row ends.
    assign underrun_set = sh_last && !s2_v && !hold_v && s1_v;

    // Sticky underrun; a new event wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               underrun <= 1'b0;
        else if (underrun_set)   underrun <= 1'b1;
        else if (clear_underrun) underrun <= 1'b0;
    end

    glyph_shifter #(.GLYPH_W(GLYPH_W)) u_shifter (
        .clk    (clk),
        .reset  (reset),
        .load   (sh_load),
        .din    (sh_din),
        .pixel  (pixel),
        .active (sh_active),
        .last   (sh_last)
    );

    assign pixel_valid = sh_active;
endmodule

// File: tb/tb_glyph_serializer.sv
// Bench for glyph_serializer: 4Kx8 synchronous ROM model, expected-pixel queue
// filled on every accepted character, per-scenario timing checks.
module tb_glyph_serializer;
    import glyph_serializer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear_underrun = 1'b0;
    logic [11:0] rom_addr;
    logic [7:0]  rom_dout = 8'h00;
    logic        pixel, pixel_valid, underrun;

    glyph_serializer_if #(.CHAR_BITS(8), .ROW_BITS(4)) chr ();

    glyph_serializer #(.CHAR_BITS(8), .ROW_BITS(4), .GLYPH_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .chr            (chr),
        .rom_addr       (rom_addr),
        .rom_dout       (rom_dout),
        .pixel          (pixel),
        .pixel_valid    (pixel_valid),
        .underrun       (underrun),
        .clear_underrun (clear_underrun)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [0:4095];
    always @(posedge clk) rom_dout <= rom[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    bit exp_q[$];
    int run = 0, max_run = 0;

    // Stream monitor: every valid pixel must be the next expected bit; idle pixel is 0.
    always @(negedge clk) begin : mon
        bit e;
        if (!reset) begin
            n_cmp++;
            if (pixel_valid) begin
                run++;
                if (run > max_run) max_run = run;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream_extra: pixel_valid=1 at cyc %0d, no pixel expected", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (pixel !== e) begin
                        n_bad++;
                        $display("FAIL stream_bit: cyc %0d got %b want %b", cyc, pixel, e);
                    end
                end
            end else begin
                run = 0;
                if (pixel !== 1'b0) begin
                    n_bad++;
                    $display("FAIL idle_pixel: cyc %0d got %b want 0", cyc, pixel);
                end
            end
        end
    end

    // Offer a character from a negedge; returns the edge number on which it was accepted.
    task automatic send(input logic [7:0] code, input logic [3:0] row, input logic inv,
                        output int acc);
        logic [7:0] b;
        chr.char_valid = 1'b1;
        chr.char_code  = code;
        chr.char_row   = row;
        chr.char_inv   = inv;
        acc = -1;
        for (int i = 0; i < 60; i++) begin
            if (chr.char_ready) begin
                acc = cyc + 1;
                b = rom[{code, row}];
`ifdef GLYPH_INVERSE_EN
                if (inv) b = ~b;
`endif
                for (int k = 7; k >= 0; k--) exp_q.push_back(b[k]);
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        chr.char_valid = 1'b0;
        if (acc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: char_ready got 0 for 60 clks want 1");
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < 2000 && cyc < n; i++) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rom_addr, pixel, pixel_valid, underrun, chr.char_ready} !== {12'h000, 4'b0001}) begin
            n_bad++;
            $display("FAIL reset_state: addr=%h pix=%b pv=%b ur=%b rdy=%b want 000,0,0,0,1",
                     rom_addr, pixel, pixel_valid, underrun, chr.char_ready);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // 0x41 row 5 -> ROM byte 0x18; first pixel after edge t+2, exactly 8 valid clks.
    task automatic test_single(input string name, input logic inv);
        int acc;
        logic [7:0] pat;
        logic vexp;
        pat = 8'h18;
`ifdef GLYPH_INVERSE_EN
        if (inv) pat = ~pat;
`endif
        send(8'h41, 4'h5, inv, acc);
        n_cmp++;
        if (rom_addr !== 12'h415) begin
            n_bad++;
            $display("FAIL %s_addr: got %h want 415", name, rom_addr);
        end
        for (int k = 1; k <= 10; k++) begin
            wait_cyc(acc + k);
            vexp = (k >= 2 && k <= 9);
            n_cmp++;
            if (pixel_valid !== vexp || (vexp && pixel !== pat[9-k])) begin
                n_bad++;
                $display("FAIL %s_pix: k=%0d got pv=%b pix=%b want pv=%b pix=%b",
                         name, k, pixel_valid, pixel, vexp, vexp ? pat[9-k] : 1'b0);
            end
        end
        n_cmp++;
        if (underrun !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_underrun: got %b want 0", name, underrun);
        end
    endtask

    task automatic test_back_to_back();
        int acc [3];
        max_run = 0;
        for (int c = 0; c < 3; c++) begin
            send(8'($urandom), 4'($urandom), 1'($urandom), acc[c]);
            n_cmp++;
            if (chr.char_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_ready_inflight: char %0d got 1 want 0", c);
            end
            if (c == 1) begin
                wait_cyc(acc[1] + 3);
                n_cmp++;
                if (chr.char_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_ready_hold: got 1 want 0");
                end
            end
        end
        drain();
        n_cmp++;
        if (max_run !== 24 || underrun !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_gapless: run=%0d ur=%b want 24,0", max_run, underrun);
        end
    endtask

    task automatic test_starvation();
        int a, b;
        send(8'($urandom), 4'($urandom), 1'b0, a);
        wait_cyc(a + 8);
        send(8'($urandom), 4'($urandom), 1'b0, b);
        n_cmp++;
        if (b !== a + 9) begin
            n_bad++;
            $display("FAIL starve_accept: edge got %0d want %0d", b - a, 9);
        end
        wait_cyc(a + 10);
        n_cmp++;
        if (pixel_valid !== 1'b0 || underrun !== 1'b1) begin
            n_bad++;
            $display("FAIL starve_gap: pv=%b ur=%b want 0,1", pixel_valid, underrun);
        end
        wait_cyc(a + 11);
        n_cmp++;
        if (pixel_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL starve_resume: pv got %b want 1", pixel_valid);
        end
        drain();
        n_cmp++;
        if (underrun !== 1'b1) begin
            n_bad++;
            $display("FAIL starve_sticky: got %b want 1", underrun);
        end
        clear_underrun = 1'b1;
        @(negedge clk);
        clear_underrun = 1'b0;
        n_cmp++;
        if (underrun !== 1'b0) begin
            n_bad++;
            $display("FAIL starve_clear: got %b want 0", underrun);
        end
    endtask

    // Second char arrives in s2 exactly on the last bit: direct load, hold stays empty.
    task automatic test_boundary();
        int a, b;
        max_run = 0;
        send(8'($urandom), 4'($urandom), 1'b0, a);
        wait_cyc(a + 7);
        send(8'($urandom), 4'($urandom), 1'b0, b);
        n_cmp++;
        if (b !== a + 8) begin
            n_bad++;
            $display("FAIL bound_accept: edge got %0d want 8", b - a);
        end
        wait_cyc(a + 10);
        n_cmp++;
        if (chr.char_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bound_nohold: char_ready got %b want 1", chr.char_ready);
        end
        drain();
        n_cmp++;
        if (max_run !== 16 || underrun !== 1'b0) begin
            n_bad++;
            $display("FAIL bound_gapless: run=%0d ur=%b want 16,0", max_run, underrun);
        end
    endtask

    task automatic test_reset_mid();
        int a, b, seen;
        send(8'($urandom), 4'($urandom), 1'b0, a);
        send(8'($urandom), 4'($urandom), 1'b0, b);
        wait_cyc(a + 5);
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        n_cmp++;
        if ({rom_addr, pixel, pixel_valid, underrun, chr.char_ready} !== {12'h000, 4'b0001}) begin
            n_bad++;
            $display("FAIL midreset_async: addr=%h pix=%b pv=%b ur=%b rdy=%b want 000,0,0,0,1",
                     rom_addr, pixel, pixel_valid, underrun, chr.char_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (pixel_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL midreset_flush: valid clks got %0d want 0", seen);
        end
        test_single("post_reset", 1'b0);
        drain();
    endtask

    task automatic test_random();
        int a;
        for (int c = 0; c < 24; c++) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            send(8'($urandom), 4'($urandom), 1'($urandom), a);
        end
        drain();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL random_drain: pixels left got %0d want 0", exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[12'h415] = 8'h18;
        chr.char_valid = 1'b0;
        chr.char_code  = '0;
        chr.char_row   = '0;
        chr.char_inv   = 1'b0;
        test_reset();
        test_single("single", 1'b0);
        drain();
        test_back_to_back();
        test_starvation();
        test_boundary();
        test_reset_mid();
        test_single("inverse", 1'b1);
        drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
